// File: rtl/central_registers.sv
// rtl/central_registers.sv - central A/L/Q/Z/B register bank with set-only writes and wired-OR read bus
module central_registers #(
    parameter int WIDTH = 16,
    parameter int SPLIT = 8
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST,
    input  logic [WIDTH:1]   WL_n,
    input  logic             CAG,
    input  logic             CLG1G,
    input  logic             CLG2G,
    input  logic             CQG,
    input  logic             CZG,
    input  logic             CBG,
    input  logic             WAG_n,
    input  logic             WLG_n,
    input  logic             WQG_n,
    input  logic             WZG_n,
    input  logic             WBG_n,
    input  logic             RAG_n,
    input  logic             RLG_n,
    input  logic             RQG_n,
    input  logic             RZG_n,
    input  logic             RBHG_n,
    input  logic             RBLG_n,
    output logic [WIDTH:1]   RL_n,
    output logic             A_OVF,
    output logic [WIDTH:1]   MA,
    output logic [WIDTH:1]   ML,
    output logic [WIDTH:1]   MQ,
    output logic [WIDTH:1]   MZ,
    output logic [WIDTH:1]   MB
);

    // L is cleared in two independent pieces: bits 14..1 and the upper bits.
    localparam int L_SPLIT = 14;
    localparam logic [WIDTH:1] B_LO_MASK = {{(WIDTH - SPLIT){1'b0}}, {SPLIT{1'b1}}};
    localparam logic [WIDTH:1] B_HI_MASK = ~B_LO_MASK;

    logic [WIDTH:1] a_reg, l_reg, q_reg, z_reg, b_reg;
    logic [WIDTH:1] wbus;
    logic [WIDTH:1] l_clr_mask;
    logic [WIDTH:1] rbus;

    assign wbus       = ~WL_n;
    assign l_clr_mask = {{(WIDTH - L_SPLIT){CLG2G}}, {L_SPLIT{CLG1G}}};

    // Clear takes effect before the write, so clear+write loads; write alone ORs in.
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            a_reg <= '0;
            l_reg <= '0;
            q_reg <= '0;
            z_reg <= '0;
            b_reg <= '0;
        end else begin
            a_reg <= (CAG ? '0 : a_reg)  | (WAG_n ? '0 : wbus);
            l_reg <= (l_reg & ~l_clr_mask) | (WLG_n ? '0 : wbus);
            q_reg <= (CQG ? '0 : q_reg)  | (WQG_n ? '0 : wbus);
            z_reg <= (CZG ? '0 : z_reg)  | (WZG_n ? '0 : wbus);
            b_reg <= (CBG ? '0 : b_reg)  | (WBG_n ? '0 : wbus);
        end
    end

    always_comb begin
        rbus = '0;
        if (!RAG_n)  rbus = rbus | a_reg;
        if (!RLG_n)  rbus = rbus | l_reg;
        if (!RQG_n)  rbus = rbus | q_reg;
        if (!RZG_n)  rbus = rbus | z_reg;
        if (!RBHG_n) rbus = rbus | (b_reg & B_HI_MASK);
        if (!RBLG_n) rbus = rbus | (b_reg & B_LO_MASK);
    end

    assign RL_n  = ~rbus;
    assign A_OVF = a_reg[WIDTH] ^ a_reg[WIDTH-1];

    assign MA = a_reg;
    assign ML = l_reg;
    assign MQ = q_reg;
    assign MZ = z_reg;
    assign MB = b_reg;

endmodule
